// File: rtl/aes_job_dispatcher.sv
// aes_job_dispatcher: buffers AES jobs, sequences key loads and issues jobs
// into the pipelined aes_engine while tracking how many are in flight.
package aes_job_pkg;
    typedef enum logic [1:0] {INVALID = 2'd0, ENCRYPT = 2'd1, DECRYPT = 2'd2} job_t;
endpackage

module aes_job_dispatcher
    import aes_job_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int KEY_CYCLES   = 10,
    parameter int MAX_INFLIGHT = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  job_t         in_type,
    input  logic [127:0] in_data,
    input  logic [127:0] in_key,
    output job_t         eng_type,
    output logic [127:0] eng_state,
    output logic [127:0] eng_key,
    output logic         eng_set_key,
    output logic         eng_halt,
    input  job_t         eng_out_type,
    input  logic         dn_stall,
    output logic         busy
);
    localparam int AW = $clog2(DEPTH);
    localparam int IW = $clog2(MAX_INFLIGHT + 1);
    localparam int CW = $clog2(KEY_CYCLES + 1);
    localparam logic [2:0] S_IDLE = 3'd0, S_DRAIN = 3'd1, S_KEYLOAD = 3'd2, S_KEYWAIT = 3'd3, S_ISSUE = 3'd4;

    job_t          q_type [DEPTH];
    logic [127:0]  q_data [DEPTH];
    logic [127:0]  q_key  [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic [IW-1:0] inflight;
    logic [CW-1:0] wait_cnt;
    logic [127:0]  cur_key;
    logic          key_valid;
    logic [2:0]    fsm, fsm_nxt, route;
    logic          empty, full, push, issue, load, dec, key_hit, issue_mode;

    assign empty      = count == '0;
    assign full       = count == (AW+1)'(DEPTH);
    assign in_ready   = !rst && !full;
    assign push       = in_valid && in_ready && in_type != INVALID;
    assign eng_halt   = dn_stall;
    assign key_hit    = key_valid && q_key[rd_ptr] == cur_key;
    // The last key-wait cycle already behaves as ISSUE so the first job lands KEY_CYCLES+1 after set_key.
    assign issue_mode = fsm == S_ISSUE || (fsm == S_KEYWAIT && wait_cnt == '0);
    assign issue      = issue_mode && !empty && key_hit && !dn_stall && inflight < IW'(MAX_INFLIGHT);
    assign load       = fsm == S_KEYLOAD && !dn_stall;
    assign dec        = eng_out_type != INVALID && !eng_halt && inflight != '0;
    assign busy       = !empty || inflight != '0 || fsm != S_IDLE;

    always_comb begin
        route   = key_hit ? S_ISSUE : (inflight != '0 ? S_DRAIN : S_KEYLOAD);
        fsm_nxt = (fsm == S_IDLE || issue_mode) ? (empty ? S_IDLE : route) :
                  fsm == S_DRAIN   ? (inflight == '0 ? S_KEYLOAD : S_DRAIN) :
                  fsm == S_KEYLOAD ? (dn_stall ? S_KEYLOAD : S_KEYWAIT) :
                  fsm == S_KEYWAIT ? S_KEYWAIT : S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_type[wr_ptr] <= in_type;
            q_data[wr_ptr] <= in_data;
            q_key[wr_ptr]  <= in_key;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm         <= S_IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            inflight    <= '0;
            wait_cnt    <= '0;
            cur_key     <= '0;
            key_valid   <= 1'b0;
            eng_type    <= INVALID;
            eng_state   <= '0;
            eng_key     <= '0;
            eng_set_key <= 1'b0;
        end else begin
            fsm         <= fsm_nxt;
            wr_ptr      <= push ? wr_ptr + AW'(1) : wr_ptr;
            rd_ptr      <= issue ? rd_ptr + AW'(1) : rd_ptr;
            count       <= (push && !issue) ? count + (AW+1)'(1) :
                           (!push && issue) ? count - (AW+1)'(1) : count;
            inflight    <= (issue && !dec) ? inflight + IW'(1) :
                           (!issue && dec) ? inflight - IW'(1) : inflight;
            wait_cnt    <= load ? CW'(KEY_CYCLES) :
                           (fsm == S_KEYWAIT && wait_cnt != '0 && !dn_stall) ? wait_cnt - CW'(1) : wait_cnt;
            cur_key     <= load ? q_key[rd_ptr] : cur_key;
            key_valid   <= key_valid || load;
            eng_type    <= issue ? q_type[rd_ptr] : INVALID;
            eng_state   <= issue ? q_data[rd_ptr] : eng_state;
            eng_key     <= issue ? cur_key : load ? q_key[rd_ptr] : eng_key;
            eng_set_key <= load;
        end
    end
endmodule

// File: tb/tb_aes_job_dispatcher.sv
// tb_aes_job_dispatcher: scoreboard bench with a simple fixed-latency engine model.
module tb_aes_job_dispatcher;
    import aes_job_pkg::*;
    localparam int DEPTH = 4, KC = 10, MI = 10, LAT = 8;
    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] D1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] D2 = 128'h3243f6a8885a308d313198a2e0370734;

    logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, dn_stall = 1'b0;
    logic in_ready, eng_set_key, eng_halt, busy;
    job_t in_type = INVALID, eng_type, eng_out_type;
    logic [127:0] in_data = '0, in_key = '0, eng_state, eng_key;

    typedef struct packed {job_t t; logic [127:0] d; logic [127:0] k;} job_s;
    job_s sb[$];
    int total = 0, bad = 0, issued = 0, retired = 0;
    job_t pipe [LAT];

    always #5 clk = ~clk;

    aes_job_dispatcher #(.DEPTH(DEPTH), .KEY_CYCLES(KC), .MAX_INFLIGHT(MI)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_type(in_type),
        .in_data(in_data), .in_key(in_key), .eng_type(eng_type), .eng_state(eng_state),
        .eng_key(eng_key), .eng_set_key(eng_set_key), .eng_halt(eng_halt),
        .eng_out_type(eng_out_type), .dn_stall(dn_stall), .busy(busy));

    initial begin
        for (int i = 0; i < LAT; i++) pipe[i] = INVALID;
        eng_out_type = INVALID;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                for (int i = 0; i < LAT; i++) pipe[i] = INVALID;
            end else if (!dn_stall) begin
                for (int i = LAT - 1; i > 0; i--) pipe[i] = pipe[i-1];
                pipe[0] = eng_type;
            end
            eng_out_type = pipe[LAT-1];
        end
    end

    initial begin
        job_s e;
        forever begin
            @(negedge clk);
            if (rst) begin
                issued = 0;
                retired = 0;
            end else begin
                if (eng_type !== INVALID) begin
                    issued++;
                    total++;
                    if (sb.size() == 0) begin
                        bad++;
                        $display("FAIL issue_unexpected: got type=%0d data=%h, required no issue", eng_type, eng_state);
                    end else begin
                        e = sb.pop_front();
                        if ({eng_type, eng_state, eng_key} !== {e.t, e.d, e.k}) begin
                            bad++;
                            $display("FAIL issue_order: got %0d/%h/%h, required %0d/%h/%h", eng_type, eng_state, eng_key, e.t, e.d, e.k);
                        end
                    end
                end
                total++;
                if (int'(dut.inflight) != issued - retired) begin
                    bad++;
                    $display("FAIL inflight_track: got %0d, required %0d", dut.inflight, issued - retired);
                end
                total++;
                if (eng_halt !== dn_stall) begin
                    bad++;
                    $display("FAIL halt_pass: got %b, required %b", eng_halt, dn_stall);
                end
                if (eng_out_type !== INVALID && !dn_stall) retired++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    task automatic offer(input job_t t, input logic [127:0] d, input logic [127:0] k, output bit acc);
        in_valid = 1'b1;
        in_type = t;
        in_data = d;
        in_key = k;
        acc = in_ready;
        if (acc && t != INVALID) sb.push_back('{t, d, k});
    endtask

    task automatic wait_idle();
        int n = 0;
        in_valid = 1'b0;
        while ((busy !== 1'b0 || sb.size() != 0) && n < 300) begin
            tick();
            n++;
        end
        total++;
        if (busy !== 1'b0 || sb.size() != 0) begin
            bad++;
            $display("FAIL idle_timeout: busy=%b pending=%0d, required 0/0", busy, sb.size());
        end
    endtask

    task automatic test_reset();
        bit acc;
        rst = 1'b1;
        repeat (3) tick();
        total++;
        if ({in_ready, eng_type, eng_state, eng_key, eng_set_key, eng_halt, busy} !== {1'b0, INVALID, 128'h0, 128'h0, 3'b000}) begin
            bad++;
            $display("FAIL reset_state: ready=%b type=%0d set_key=%b busy=%b, required 0/0/0/0", in_ready, eng_type, eng_set_key, busy);
        end
        rst = 1'b0;
        tick();
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL ready_after_reset: got %b, required 1", in_ready);
        end
        offer(ENCRYPT, D1, K2, acc);
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (in_ready !== 1'b0) begin
                bad++;
                $display("FAIL ready_in_reset: got %b, required 0", in_ready);
            end
        end
        total++;
        if ({eng_type, eng_state, eng_key, eng_set_key, busy} !== {INVALID, 128'h0, 128'h0, 2'b00}) begin
            bad++;
            $display("FAIL midreset_state: type=%0d key=%h set_key=%b busy=%b, required 0/0/0/0", eng_type, eng_key, eng_set_key, busy);
        end
        sb.delete();
        rst = 1'b0;
        repeat (20) tick();
        total++;
        if (issued != 0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL midreset_discard: issued=%0d busy=%b, required 0/0", issued, busy);
        end
    endtask

    task automatic test_first_job();
        bit acc;
        int n = 0;
        offer(ENCRYPT, D1, K1, acc);
        tick();
        in_valid = 1'b0;
        while (eng_set_key !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        total++;
        if (eng_set_key !== 1'b1 || eng_key !== K1) begin
            bad++;
            $display("FAIL first_setkey: set_key=%b key=%h, required 1/%h", eng_set_key, eng_key, K1);
        end
        n = 0;
        do begin
            tick();
            n++;
            if (n == 1) begin
                total++;
                if (eng_set_key !== 1'b0) begin
                    bad++;
                    $display("FAIL setkey_pulse: got %b, required 0", eng_set_key);
                end
            end
        end while (eng_type === INVALID && n < 40);
        total++;
        if (n != KC + 1) begin
            bad++;
            $display("FAIL first_latency: got %0d, required %0d", n, KC + 1);
        end
        wait_idle();
    endtask

    task automatic test_streaming();
        int sent = 0, first = -1, last = -1, cnt = 0, peak = 0;
        for (int c = 0; c < 60; c++) begin
            bit acc = 1'b0;
            if (sent < 6) offer(ENCRYPT, D1 + 128'(sent), K1, acc);
            else in_valid = 1'b0;
            tick();
            if (acc) sent++;
            if (eng_type !== INVALID) begin
                if (first < 0) first = c;
                last = c;
                cnt++;
            end
            if (int'(dut.inflight) > peak) peak = int'(dut.inflight);
        end
        total++;
        if (cnt != 6 || last - first != 5) begin
            bad++;
            $display("FAIL stream_b2b: issues=%0d span=%0d, required 6/5", cnt, last - first);
        end
        total++;
        if (peak != 6) begin
            bad++;
            $display("FAIL stream_peak: got %0d, required 6", peak);
        end
        total++;
        if (dut.inflight !== '0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL stream_drain: inflight=%0d busy=%b, required 0/0", dut.inflight, busy);
        end
    endtask

    task automatic test_key_change();
        int i = 0, n = 0;
        while (i < 4 && n < 40) begin
            bit acc;
            offer(ENCRYPT, D2 + 128'(i), (i < 3) ? K1 : K2, acc);
            tick();
            if (acc) i++;
            n++;
        end
        in_valid = 1'b0;
        n = 0;
        while (eng_set_key !== 1'b1 && n < 80) begin
            tick();
            n++;
        end
        total++;
        if (eng_set_key !== 1'b1 || eng_key !== K2 || dut.inflight !== '0 || sb.size() != 1) begin
            bad++;
            $display("FAIL keychange_setkey: set_key=%b key=%h inflight=%0d pending=%0d, required 1/%h/0/1", eng_set_key, eng_key, dut.inflight, sb.size(), K2);
        end
        n = 0;
        do begin
            tick();
            n++;
        end while (eng_type === INVALID && n < 40);
        total++;
        if (n != KC + 1) begin
            bad++;
            $display("FAIL keychange_latency: got %0d, required %0d", n, KC + 1);
        end
        wait_idle();
    endtask

    task automatic test_backpressure();
        int acc_n = 0, iss0;
        bit acc;
        dn_stall = 1'b1;
        tick();
        iss0 = issued;
        for (int c = 0; c < DEPTH + 2; c++) begin
            offer((acc_n % 2) ? DECRYPT : ENCRYPT, D2 ^ 128'(acc_n + 16), K2, acc);
            tick();
            if (acc) acc_n++;
        end
        repeat (3) tick();
        total++;
        if (acc_n != DEPTH || in_ready !== 1'b0 || eng_halt !== 1'b1 || issued != iss0) begin
            bad++;
            $display("FAIL bp_full: accepted=%0d ready=%b halt=%b issues=%0d, required %0d/0/1/0", acc_n, in_ready, eng_halt, issued - iss0, DEPTH);
        end
        dn_stall = 1'b0;
        offer(ENCRYPT, D2 ^ 128'(20), K2, acc);
        tick();
        total++;
        if (acc || dut.count !== 3'(DEPTH - 1)) begin
            bad++;
            $display("FAIL bp_release: acc=%b count=%0d, required 0/%0d", acc, dut.count, DEPTH - 1);
        end
        for (int j = 0; j < 2; j++) begin
            offer(ENCRYPT, D2 ^ 128'(20 + j), K2, acc);
            tick();
            total++;
            if (!acc || dut.count !== 3'(DEPTH - 1)) begin
                bad++;
                $display("FAIL push_pop_same: acc=%b count=%0d, required 1/%0d", acc, dut.count, DEPTH - 1);
            end
        end
        wait_idle();
    endtask

    task automatic test_invalid_and_overlap();
        bit acc;
        int iss0 = issued, sent = 0, overlap = 0;
        for (int c = 0; c < 3; c++) begin
            offer(INVALID, D1, K1, acc);
            tick();
        end
        in_valid = 1'b0;
        repeat (5) tick();
        total++;
        if (dut.count !== '0 || busy !== 1'b0 || issued != iss0) begin
            bad++;
            $display("FAIL invalid_drop: count=%0d busy=%b issues=%0d, required 0/0/0", dut.count, busy, issued - iss0);
        end
        for (int c = 0; c < 80; c++) begin
            bit r;
            int pi;
            acc = 1'b0;
            if (sent < 12) offer(DECRYPT, D1 ^ 128'(sent + 100), K2, acc);
            else in_valid = 1'b0;
            r = eng_out_type !== INVALID && !dn_stall;
            pi = int'(dut.inflight);
            tick();
            if (acc) sent++;
            if (eng_type !== INVALID && r) begin
                overlap++;
                total++;
                if (int'(dut.inflight) != pi) begin
                    bad++;
                    $display("FAIL issue_retire_same: got %0d, required %0d", dut.inflight, pi);
                end
            end
        end
        total++;
        if (overlap == 0) begin
            bad++;
            $display("FAIL overlap_seen: got 0 coincident cycles, required >0");
        end
        wait_idle();
    endtask

    initial begin
        test_reset();
        test_first_job();
        test_streaming();
        test_key_change();
        test_backpressure();
        test_invalid_and_overlap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
